// File: rtl/sync_tx.sv
// J/K line transmitter: SYNC (KJKJKJKK), NRZI payload LSB first, SE0 EOP, closing J.
// Optional bit stuffing after six consecutive ones is enabled by defining BIT_STUFF_EN.
module sync_tx #(
  parameter int PAYLOAD_W = 8,
  parameter int EOP_LEN   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] data_in,
  output logic                 ready,
  output logic                 tx_en,
  output logic                 tx_k,
  output logic                 tx_j,
  output logic                 done
);

  localparam int BW = $clog2(PAYLOAD_W + 1);
  localparam logic [BW-1:0] LP_PW  = BW'(PAYLOAD_W);
  localparam logic [3:0]    LP_EOP = 4'(EOP_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ENDJ} state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [BW-1:0]        r_bitcnt;
  logic [PAYLOAD_W-1:0] r_shift;

  logic w_accept;
  logic w_stuff;
  logic w_sync_last;
  logic w_data_more;
  logic w_take;
  logic w_bit;
  logic w_nk;
  logic w_nj;
  logic w_sync_k;

`ifdef BIT_STUFF_EN
  logic [2:0] r_ones;
  assign w_stuff = (r_state == S_DATA) && (r_ones == 3'd6);
`else
  assign w_stuff = 1'b0;
`endif

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_sync_last = (r_state == S_SYNC) && (r_cnt == 4'd8);
  assign w_data_more = (r_state == S_DATA) && !w_stuff && (r_bitcnt != LP_PW);
  assign w_take      = w_sync_last || w_data_more;
  assign w_bit       = r_shift[0];
  // NRZI: a 0 toggles the line, a 1 holds it; the line is always J or K here
  assign w_nk        = w_bit ? tx_k : ~tx_k;
  assign w_nj        = w_bit ? tx_j : ~tx_j;
  // r_cnt is the index of the SYNC symbol about to be sent (1..7)
  assign w_sync_k    = ~r_cnt[0] || (r_cnt == 4'd7);

  // Payload shift register: pure data, no reset needed
  always_ff @(posedge CLK) begin
    if (w_accept)
      r_shift <= data_in;
    else if (w_take)
      r_shift <= r_shift >> 1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_bitcnt <= '0;
      ready    <= 1'b1;
      tx_en    <= 1'b0;
      tx_k     <= 1'b0;
      tx_j     <= 1'b1;
      done     <= 1'b0;
`ifdef BIT_STUFF_EN
      r_ones   <= 3'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SYNC;
            r_cnt   <= 4'd1;
            ready   <= 1'b0;
            tx_en   <= 1'b1;
            tx_k    <= 1'b1;
            tx_j    <= 1'b0;
          end
        end
        S_SYNC: begin
          if (w_sync_last) begin
            r_state  <= S_DATA;
            r_bitcnt <= BW'(1);
            tx_k     <= w_nk;
            tx_j     <= w_nj;
`ifdef BIT_STUFF_EN
            r_ones   <= w_bit ? 3'd1 : 3'd0;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
            tx_k  <= w_sync_k;
            tx_j  <= ~w_sync_k;
          end
        end
        S_DATA: begin
          if (w_stuff) begin
            // Stuffed 0: forced toggle that does not consume a payload bit
            tx_k <= ~tx_k;
            tx_j <= ~tx_j;
`ifdef BIT_STUFF_EN
            r_ones <= 3'd0;
`endif
          end else if (r_bitcnt == LP_PW) begin
            r_state <= S_EOP;
            r_cnt   <= 4'd1;
            tx_k    <= 1'b0;
            tx_j    <= 1'b0;
          end else begin
            r_bitcnt <= r_bitcnt + BW'(1);
            tx_k     <= w_nk;
            tx_j     <= w_nj;
`ifdef BIT_STUFF_EN
            r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
`endif
          end
        end
        S_EOP: begin
          if (r_cnt == LP_EOP) begin
            r_state <= S_ENDJ;
            tx_k    <= 1'b0;
            tx_j    <= 1'b1;
            done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ENDJ: begin
          r_state <= S_IDLE;
          ready   <= 1'b1;
          tx_en   <= 1'b0;
          tx_k    <= 1'b0;
          tx_j    <= 1'b1;
          done    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_tx.sv
// Bench for sync_tx: frames are predicted symbol-by-symbol from a queue-based line model.
module tb_sync_tx;

  localparam int PW = 8;
  localparam int EL = 2;
  localparam logic [1:0] SYM_K   = 2'b10;
  localparam logic [1:0] SYM_J   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [4:0] IDLE_V  = 5'b10010;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] data_in = '0;
  logic          ready, tx_en, tx_k, tx_j, done;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  sync_tx #(.PAYLOAD_W(PW), .EOP_LEN(EL)) dut (
    .CLK(CLK), .RST(RST), .start(start), .data_in(data_in),
    .ready(ready), .tx_en(tx_en), .tx_k(tx_k), .tx_j(tx_j), .done(done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Line-level model: list of {k,j} symbols a frame carrying d must produce
  task automatic build(input logic [PW-1:0] d);
    logic [1:0] line;
    int ones;
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      exp_q.push_back(((i % 2) == 0 || i == 7) ? SYM_K : SYM_J);
    line = SYM_K;
    ones = 0;
    for (int i = 0; i < PW; i++) begin
      if (d[i] == 1'b0) begin
        line = (line == SYM_K) ? SYM_J : SYM_K;
        ones = 0;
      end else begin
        ones++;
      end
      exp_q.push_back(line);
`ifdef BIT_STUFF_EN
      if (ones == 6) begin
        line = (line == SYM_K) ? SYM_J : SYM_K;
        exp_q.push_back(line);
        ones = 0;
      end
`endif
    end
    for (int e = 0; e < EL; e++) exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_J);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after the frame
  task automatic run_frame(input logic [PW-1:0] d, input bit hold, input bit pulse, input string tag);
    logic [4:0] obs, expv;
    int n;
    build(d);
    n = exp_q.size();
    start   = 1'b1;
    data_in = d;
    @(negedge CLK);
    for (int i = 0; i < n; i++) begin
      obs  = {ready, tx_en, tx_k, tx_j, done};
      expv = {1'b0, 1'b1, exp_q[i], (i == n - 1)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s data=%h sym%0d: got rdy/en/k/j/done=%b want %b", tag, d, i, obs, expv);
      end
      if (!hold) start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      data_in = PW'($urandom);
      @(negedge CLK);
    end
    obs = {ready, tx_en, tx_k, tx_j, done};
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL %s idle-after data=%h: got %b want %b", tag, d, obs, IDLE_V);
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    logic [4:0] obs;
    obs = {ready, tx_en, tx_k, tx_j, done};
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL %s: got rdy/en/k/j/done=%b want %b", tag, obs, IDLE_V);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_idle("reset_values");
    start   = 1'b1;
    data_in = PW'($urandom);
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1 check_idle("reset_async_mid_sync");
    @(negedge CLK);
    RST = 1'b0;
    check_idle("reset_release");
    @(negedge CLK);
    check_idle("reset_no_partial_frame");
  endtask

  task automatic test_fixed();
    run_frame(8'h00, 1'b0, 1'b0, "zeros");
    @(negedge CLK);
    run_frame(8'hFF, 1'b0, 1'b0, "ones");
    @(negedge CLK);
    run_frame(8'h3F, 1'b0, 1'b0, "six_ones");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      run_frame(PW'($urandom), 1'b0, 1'b1, "random");
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++)
      run_frame(PW'($urandom), 1'b1, 1'b0, "back_to_back");
    start = 1'b0;
    @(negedge CLK);
    check_idle("back_to_back_release");
  endtask

  initial begin
    test_reset();
    test_fixed();
    @(negedge CLK);
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
